writeback_arbiter: RTL and testbench

//  Writeback side of the scoreboard protocol. Collects completed results from

---
 rtl/writeback_arbiter.sv | 194 +++++++++++++++++++
 tb/tb_writeback_arbiter.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/writeback_arbiter.sv
// Writeback arbiter: per-source 2-entry FIFOs feeding round-robin
// arbitration onto one scalar and one vector writeback port.
module wb_arb_chan #(
  parameter int N = 3,
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] in_valid_i,
  output logic [N-1:0] in_ready_o,
  input  logic [N*W-1:0] in_data_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] out_data_o,
  output logic         out_fire_o
);
  localparam int GW = (N > 1) ? $clog2(N) : 1;

  logic [1:0]    cnt_q [N];
  logic [1:0]    cnt_d [N];
  logic [W-1:0]  mem_q [N][2];
  logic [W-1:0]  mem_d [N][2];
  logic [GW-1:0] rr_q, rr_d, gnt;
  logic          found, load;
  logic          vld_q, vld_d;
  logic [W-1:0]  dat_q, dat_d;

  always_comb begin
    for (int i = 0; i < N; i++)
      in_ready_o[i] = rst_n && (cnt_q[i] != 2'd2);
  end

  assign out_valid_o = vld_q;
  assign out_data_o  = dat_q;
  assign out_fire_o  = vld_q & out_ready_i;
  assign load        = !vld_q || out_ready_i;

  // two passes: sources at/after rr_q first, then wrap to the low ones
  always_comb begin
    found = 1'b0;
    gnt   = '0;
    for (int i = 0; i < N; i++)
      if (!found && GW'(i) >= rr_q && cnt_q[i] != 2'd0) begin
        found = 1'b1;
        gnt   = GW'(i);
      end
    for (int i = 0; i < N; i++)
      if (!found && cnt_q[i] != 2'd0) begin
        found = 1'b1;
        gnt   = GW'(i);
      end
  end

  always_comb begin
    cnt_d = cnt_q;
    mem_d = mem_q;
    rr_d  = rr_q;
    vld_d = vld_q && !out_ready_i;
    dat_d = dat_q;
    if (load && found) begin
      vld_d          = 1'b1;
      dat_d          = mem_q[gnt][0];
      mem_d[gnt][0]  = mem_q[gnt][1];
      cnt_d[gnt]     = cnt_q[gnt] - 2'd1;
      rr_d = (gnt == GW'(N-1)) ? '0 : gnt + 1'b1;
    end
    // push lands behind whatever survives the pop
    for (int i = 0; i < N; i++)
      if (in_valid_i[i] && in_ready_o[i]) begin
        mem_d[i][cnt_d[i][0]] = in_data_i[i*W +: W];
        cnt_d[i] = cnt_d[i] + 2'd1;
      end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++)
        cnt_q[i] <= '0;
      rr_q  <= '0;
      vld_q <= 1'b0;
      dat_q <= '0;
    end else begin
      for (int i = 0; i < N; i++)
        cnt_q[i] <= cnt_d[i];
      rr_q  <= rr_d;
      vld_q <= vld_d;
      dat_q <= dat_d;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      mem_q[i][0] <= mem_d[i][0];
      mem_q[i][1] <= mem_d[i][1];
    end
  end
endmodule

module writeback_arbiter #(
  parameter int NX   = 3,
  parameter int NV   = 3,
  parameter int RW   = 8,
  parameter int WIDW = 2,
  parameter int XLEN = 32,
  parameter int NT   = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NX-1:0]        x_in_valid_i,
  output logic [NX-1:0]        x_in_ready_o,
  input  logic [NX*WIDW-1:0]   x_in_wid_i,
  input  logic [NX*RW-1:0]     x_in_idx_i,
  input  logic [NX-1:0]        x_in_wxd_i,
  input  logic [NX*XLEN-1:0]   x_in_data_i,
  input  logic [NV-1:0]        v_in_valid_i,
  output logic [NV-1:0]        v_in_ready_o,
  input  logic [NV*WIDW-1:0]   v_in_wid_i,
  input  logic [NV*RW-1:0]     v_in_idx_i,
  input  logic [NV-1:0]        v_in_wvd_i,
  input  logic [NV*NT-1:0]     v_in_mask_i,
  input  logic [NV*NT*XLEN-1:0] v_in_data_i,
  output logic                 wb_x_valid_o,
  input  logic                 wb_x_ready_i,
  output logic [WIDW-1:0]      wb_x_wid_o,
  output logic [RW-1:0]        wb_x_reg_idxw_o,
  output logic                 wb_x_wxd_o,
  output logic [XLEN-1:0]      wb_x_data_o,
  output logic                 wb_x_fire_o,
  output logic                 wb_v_valid_o,
  input  logic                 wb_v_ready_i,
  output logic [WIDW-1:0]      wb_v_wid_o,
  output logic [RW-1:0]        wb_v_reg_idxw_o,
  output logic                 wb_v_wvd_o,
  output logic [NT-1:0]        wb_v_mask_o,
  output logic [NT*XLEN-1:0]   wb_v_data_o,
  output logic                 wb_v_fire_o
);
  localparam int XW = WIDW + RW + 1 + XLEN;
  localparam int VW = WIDW + RW + 1 + NT + NT*XLEN;

  logic [NX*XW-1:0] x_pl;
  logic [NV*VW-1:0] v_pl;
  logic [XW-1:0]    x_out;
  logic [VW-1:0]    v_out;

  // x0 writes are squashed on entry so they still flow and fire
  for (genvar s = 0; s < NX; s++) begin : g_x
    assign x_pl[s*XW +: XW] = {
      x_in_wid_i[s*WIDW +: WIDW],
      x_in_idx_i[s*RW +: RW],
      x_in_wxd_i[s] & (x_in_idx_i[s*RW +: RW] != '0),
      x_in_data_i[s*XLEN +: XLEN]
    };
  end

  for (genvar s = 0; s < NV; s++) begin : g_v
    assign v_pl[s*VW +: VW] = {
      v_in_wid_i[s*WIDW +: WIDW],
      v_in_idx_i[s*RW +: RW],
      v_in_wvd_i[s],
      v_in_mask_i[s*NT +: NT],
      v_in_data_i[s*NT*XLEN +: NT*XLEN]
    };
  end

  wb_arb_chan #(.N(NX), .W(XW)) u_x (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid_i  (x_in_valid_i),
    .in_ready_o  (x_in_ready_o),
    .in_data_i   (x_pl),
    .out_valid_o (wb_x_valid_o),
    .out_ready_i (wb_x_ready_i),
    .out_data_o  (x_out),
    .out_fire_o  (wb_x_fire_o)
  );

  wb_arb_chan #(.N(NV), .W(VW)) u_v (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid_i  (v_in_valid_i),
    .in_ready_o  (v_in_ready_o),
    .in_data_i   (v_pl),
    .out_valid_o (wb_v_valid_o),
    .out_ready_i (wb_v_ready_i),
    .out_data_o  (v_out),
    .out_fire_o  (wb_v_fire_o)
  );

  assign {wb_x_wid_o, wb_x_reg_idxw_o,
          wb_x_wxd_o, wb_x_data_o} = x_out;
  assign {wb_v_wid_o, wb_v_reg_idxw_o, wb_v_wvd_o,
          wb_v_mask_o, wb_v_data_o} = v_out;
endmodule

// File: tb/tb_writeback_arbiter.sv
// Randomized bench for writeback_arbiter against a queue-based
// reference model of both writeback channels.
module tb_writeback_arbiter;
  localparam int NX = 3, NV = 3, RW = 8, WIDW = 2;
  localparam int XLEN = 32, NT = 8;
  localparam int VW = WIDW + RW + 1 + NT + NT*XLEN;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [NX-1:0]          x_in_valid_i = '0;
  logic [NX-1:0]          x_in_ready_o;
  logic [NX*WIDW-1:0]     x_in_wid_i = '0;
  logic [NX*RW-1:0]       x_in_idx_i = '0;
  logic [NX-1:0]          x_in_wxd_i = '0;
  logic [NX*XLEN-1:0]     x_in_data_i = '0;
  logic [NV-1:0]          v_in_valid_i = '0;
  logic [NV-1:0]          v_in_ready_o;
  logic [NV*WIDW-1:0]     v_in_wid_i = '0;
  logic [NV*RW-1:0]       v_in_idx_i = '0;
  logic [NV-1:0]          v_in_wvd_i = '0;
  logic [NV*NT-1:0]       v_in_mask_i = '0;
  logic [NV*NT*XLEN-1:0]  v_in_data_i = '0;
  logic                   wb_x_valid_o, wb_x_ready_i = 1'b0;
  logic [WIDW-1:0]        wb_x_wid_o;
  logic [RW-1:0]          wb_x_reg_idxw_o;
  logic                   wb_x_wxd_o, wb_x_fire_o;
  logic [XLEN-1:0]        wb_x_data_o;
  logic                   wb_v_valid_o, wb_v_ready_i = 1'b0;
  logic [WIDW-1:0]        wb_v_wid_o;
  logic [RW-1:0]          wb_v_reg_idxw_o;
  logic                   wb_v_wvd_o, wb_v_fire_o;
  logic [NT-1:0]          wb_v_mask_o;
  logic [NT*XLEN-1:0]     wb_v_data_o;

  writeback_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .x_in_valid_i(x_in_valid_i), .x_in_ready_o(x_in_ready_o),
    .x_in_wid_i(x_in_wid_i), .x_in_idx_i(x_in_idx_i),
    .x_in_wxd_i(x_in_wxd_i), .x_in_data_i(x_in_data_i),
    .v_in_valid_i(v_in_valid_i), .v_in_ready_o(v_in_ready_o),
    .v_in_wid_i(v_in_wid_i), .v_in_idx_i(v_in_idx_i),
    .v_in_wvd_i(v_in_wvd_i), .v_in_mask_i(v_in_mask_i),
    .v_in_data_i(v_in_data_i),
    .wb_x_valid_o(wb_x_valid_o), .wb_x_ready_i(wb_x_ready_i),
    .wb_x_wid_o(wb_x_wid_o), .wb_x_reg_idxw_o(wb_x_reg_idxw_o),
    .wb_x_wxd_o(wb_x_wxd_o), .wb_x_data_o(wb_x_data_o),
    .wb_x_fire_o(wb_x_fire_o),
    .wb_v_valid_o(wb_v_valid_o), .wb_v_ready_i(wb_v_ready_i),
    .wb_v_wid_o(wb_v_wid_o), .wb_v_reg_idxw_o(wb_v_reg_idxw_o),
    .wb_v_wvd_o(wb_v_wvd_o), .wb_v_mask_o(wb_v_mask_o),
    .wb_v_data_o(wb_v_data_o), .wb_v_fire_o(wb_v_fire_o)
  );

  always #5 clk = ~clk;

  // stimulus state
  logic          rn;
  logic          xr, vr;
  logic [2:0]    xv, vv;
  logic [WIDW-1:0] xwid [3], vwid [3];
  logic [RW-1:0] xidx [3], vidx [3];
  logic          xwxd [3], vwvd [3];
  logic [XLEN-1:0] xdat [3];
  logic [NT-1:0] vmsk [3];
  logic [NT*XLEN-1:0] vdat [3];
  logic [VW-1:0] pl [2][3];

  // reference model
  logic [VW-1:0] mq [2][3][$];
  logic [VW-1:0] mout [2];
  bit            mvld [2];
  bit            mclean [2];
  int            mrr [2];

  int nvec = 0;
  int nerr = 0;

  task automatic chk(string tag, logic [VW-1:0] got,
                     logic [VW-1:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp,
               $time);
    end
  endtask

  task automatic step(int c, logic [2:0] inv, bit ordy);
    bit acc [3];
    bit done;
    int s;
    if (!rn) begin
      for (int k = 0; k < 3; k++) mq[c][k].delete();
      mvld[c] = 0;
      mout[c] = '0;
      mrr[c] = 0;
      mclean[c] = 1;
      return;
    end
    for (int k = 0; k < 3; k++)
      acc[k] = inv[k] && (mq[c][k].size() < 2);
    if (mvld[c] && ordy) mvld[c] = 0;
    done = 0;
    if (!mvld[c])
      for (int k = 0; k < 3; k++) begin
        s = (mrr[c] + k) % 3;
        if (!done && mq[c][s].size() > 0) begin
          mout[c] = mq[c][s].pop_front();
          mvld[c] = 1;
          mclean[c] = 0;
          mrr[c] = (s + 1) % 3;
          done = 1;
        end
      end
    for (int k = 0; k < 3; k++)
      if (acc[k]) mq[c][k].push_back(pl[c][k]);
  endtask

  task automatic rnd_fields();
    for (int s = 0; s < 3; s++) begin
      xwid[s] = WIDW'($urandom);
      xidx[s] = RW'($urandom);
      xwxd[s] = 1'($urandom);
      xdat[s] = $urandom;
      vwid[s] = WIDW'($urandom);
      vidx[s] = RW'($urandom);
      vwvd[s] = 1'($urandom);
      vmsk[s] = NT'($urandom);
      for (int l = 0; l < NT; l++)
        vdat[s][l*XLEN +: XLEN] = $urandom;
    end
  endtask

  task automatic tick();
    logic [2:0] er;
    @(negedge clk);
    rst_n = rn;
    wb_x_ready_i = xr;
    wb_v_ready_i = vr;
    x_in_valid_i = xv;
    v_in_valid_i = vv;
    for (int s = 0; s < 3; s++) begin
      x_in_wid_i[s*WIDW +: WIDW] = xwid[s];
      x_in_idx_i[s*RW +: RW] = xidx[s];
      x_in_wxd_i[s] = xwxd[s];
      x_in_data_i[s*XLEN +: XLEN] = xdat[s];
      v_in_wid_i[s*WIDW +: WIDW] = vwid[s];
      v_in_idx_i[s*RW +: RW] = vidx[s];
      v_in_wvd_i[s] = vwvd[s];
      v_in_mask_i[s*NT +: NT] = vmsk[s];
      v_in_data_i[s*NT*XLEN +: NT*XLEN] = vdat[s];
      pl[0][s] = VW'({xwid[s], xidx[s],
                      xwxd[s] && (xidx[s] != '0), xdat[s]});
      pl[1][s] = {vwid[s], vidx[s], vwvd[s], vmsk[s], vdat[s]};
    end
    #1;
    for (int s = 0; s < 3; s++) er[s] = rn && mq[0][s].size() < 2;
    chk("x_rdy", VW'(x_in_ready_o), VW'(er));
    chk("x_vld", VW'(wb_x_valid_o), VW'(mvld[0]));
    chk("x_fire", VW'(wb_x_fire_o), VW'(mvld[0] && xr));
    if (mvld[0] || mclean[0])
      chk("x_pl", VW'({wb_x_wid_o, wb_x_reg_idxw_o, wb_x_wxd_o,
                       wb_x_data_o}), mout[0]);
    for (int s = 0; s < 3; s++) er[s] = rn && mq[1][s].size() < 2;
    chk("v_rdy", VW'(v_in_ready_o), VW'(er));
    chk("v_vld", VW'(wb_v_valid_o), VW'(mvld[1]));
    chk("v_fire", VW'(wb_v_fire_o), VW'(mvld[1] && vr));
    if (mvld[1] || mclean[1])
      chk("v_pl", {wb_v_wid_o, wb_v_reg_idxw_o, wb_v_wvd_o,
                   wb_v_mask_o, wb_v_data_o}, mout[1]);
    step(0, xv, xr);
    step(1, vv, vr);
  endtask

  initial begin
    for (int c = 0; c < 2; c++) begin
      mvld[c] = 0; mout[c] = '0; mrr[c] = 0; mclean[c] = 1;
    end
    rnd_fields();
    rn = 0; xr = 1; vr = 1; xv = '0; vv = '0;
    repeat (2) tick();
    rn = 1;
    tick();
    // single scalar push from source 1
    xv = 3'b010; xidx[1] = 8'd5; xdat[1] = 32'hDEAD; xwxd[1] = 1;
    tick();
    xv = '0;
    repeat (4) tick();
    // all scalar sources push every cycle
    repeat (30) begin
      rnd_fields(); xv = 3'b111; tick();
    end
    xv = '0;
    repeat (4) tick();
    // scalar stall with pushes, then drain
    xr = 0;
    repeat (10) begin
      rnd_fields(); xv = 3'b111; tick();
    end
    xr = 1; xv = '0;
    repeat (10) tick();
    // x0 destination
    rnd_fields(); xv = 3'b001; xidx[0] = '0; xwxd[0] = 1;
    tick();
    xv = '0;
    repeat (3) tick();
    // lone vector source 2 with scalar traffic
    rnd_fields(); vv = 3'b100; vmsk[2] = 8'h0F; vidx[2] = 8'd3;
    xv = 3'b101;
    tick();
    vv = '0;
    repeat (4) begin
      rnd_fields(); xv = 3'($urandom); tick();
    end
    xv = '0;
    // pile up, then reset mid-operation
    xr = 0; vr = 0;
    repeat (4) begin
      rnd_fields(); xv = 3'b111; vv = 3'b111; tick();
    end
    xv = '0; vv = '0; rn = 0;
    tick();
    rn = 1; xr = 1; vr = 1;
    repeat (3) tick();
    // random traffic
    repeat (2500) begin
      rnd_fields();
      xv = 3'($urandom);
      vv = 3'($urandom);
      xr = ($urandom_range(0, 9) < 7);
      vr = ($urandom_range(0, 9) < 6);
      rn = ($urandom_range(0, 199) != 0);
      tick();
    end
    rn = 1; xv = '0; vv = '0; xr = 1; vr = 1;
    repeat (8) tick();
    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end
endmodule
